// File: rtl/signed_sat_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : signed_sat_accumulator
//  Description : Streaming accumulator. Sums a frame of COUNT signed
//                two's-complement samples, clamping to the WIDTH-bit signed
//                range after every single addition, then presents one result
//                per frame. Both sides use a valid/ready handshake.
//                When SIGNED_SAT_ACC_STICKY_EN is defined, the block also has
//                a sat_seen output. It flags any clamp that happened during
//                the frame being presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_sat_accumulator #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SIGNED_SAT_ACC_STICKY_EN
    ,
    output logic             sat_seen
`endif
);

    // The sample counter needs at least one bit, even when COUNT is 1.
    localparam int                 c_CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(COUNT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Two states with an explicit 1-bit encoding.
    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_sum;
    logic               w_pos_ovf;
    logic               w_neg_ovf;
    logic               w_sat_step;
    logic [WIDTH-1:0]   w_step_result;
    logic               w_accept;
    logic               w_last;

    // One saturating addition step: a wrapped sum plus a clamp on signed overflow.
    always_comb begin
        w_sum         = r_acc + in_data;
        w_pos_ovf     = ~r_acc[WIDTH-1] & ~in_data[WIDTH-1] &  w_sum[WIDTH-1];
        w_neg_ovf     =  r_acc[WIDTH-1] &  in_data[WIDTH-1] & ~w_sum[WIDTH-1];
        w_sat_step    = w_pos_ovf | w_neg_ovf;
        w_step_result = w_sum;
        if (w_pos_ovf) begin
            w_step_result = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (w_neg_ovf) begin
            w_step_result = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    // Handshake decode uses registered state only. rst blocks acceptance.
    always_comb begin
        in_ready  = (r_state == ST_ACC) && !rst;
        out_valid = r_out_valid;
        out_data  = r_acc;
        w_accept  = in_valid && in_ready;
        w_last    = (r_cnt == c_CNT_LAST);
    end

    // Frame sequencing: accumulate COUNT samples, then hold the result until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_step_result;
                        if (w_last) begin
                            r_cnt       <= '0;
                            r_state     <= ST_OUT;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                end
                ST_OUT: begin
                    // acc is the presented result, so it stays frozen until the consumer takes it.
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_state     <= ST_ACC;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACC;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIGNED_SAT_ACC_STICKY_EN
    logic r_sat_seen;

    // Sticky clamp flag for the current frame. It is cleared when the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_seen <= 1'b0;
        end else if (r_state == ST_OUT) begin
            if (out_ready) begin
                r_sat_seen <= 1'b0;
            end
        end else if (w_accept && w_sat_step) begin
            r_sat_seen <= 1'b1;
        end
    end

    assign sat_seen = r_sat_seen;
`endif

endmodule
`default_nettype wire

// File: tb/tb_signed_sat_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signed_sat_accumulator
//  Description : Directed self-checking bench for signed_sat_accumulator.
//                It covers a WIDTH=4, COUNT=4 instance and a WIDTH=4,
//                COUNT=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_sat_accumulator;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid,  in_ready,  out_valid,  out_ready;
    logic [3:0] in_data,   out_data;
    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [3:0] in_data1,  out_data1;
`ifdef SIGNED_SAT_ACC_STICKY_EN
    logic       sat_seen, sat_seen1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    signed_sat_accumulator #(.WIDTH(4), .COUNT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SIGNED_SAT_ACC_STICKY_EN
        ,
        .sat_seen  (sat_seen)
`endif
    );

    signed_sat_accumulator #(.WIDTH(4), .COUNT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1)
`ifdef SIGNED_SAT_ACC_STICKY_EN
        ,
        .sat_seen  (sat_seen1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_sat(input string tag, input logic exp);
`ifdef SIGNED_SAT_ACC_STICKY_EN
        chk(tag, {31'd0, sat_seen}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed four samples back-to-back with out_ready high. Then check the result
    // cycle and the return to ACC.
    task automatic run_frame(input string tag,
                             input logic [3:0] s0, input logic [3:0] s1,
                             input logic [3:0] s2, input logic [3:0] s3,
                             input logic [3:0] exp, input logic exp_sat);
        logic [3:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
            if (i == 3) chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
            step();
        end
        in_valid = 1'b0;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"},  {28'd0, out_data},  {28'd0, exp});
        chk({tag, "_busy"},  {31'd0, in_ready},  32'd0);
        chk_sat({tag, "_sat"}, exp_sat);
        step();
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0; in_data  = 4'h0; out_ready  = 1'b0;
        in_valid1  = 1'b0; in_data1 = 4'h0; out_ready1 = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {28'd0, out_data},  32'd0);
        chk_sat("rst_sat", 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // 1+2=3, +3=6, 6-4=2: no clamp
        run_frame("f_basic", 4'd1, 4'd2, 4'd3, 4'hC, 4'h2, 1'b0);
        // 7+1 clamps to 7, and 7 stays pinned
        run_frame("f_posclamp", 4'd7, 4'd1, 4'd1, 4'd1, 4'h7, 1'b1);
        // The sticky flag clears after the handshake
        run_frame("f_zero", 4'd0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0);
        // -8-1 clamps to -8, then -8+3=-5, then -5+0=-5
        run_frame("f_negclamp", 4'h8, 4'hF, 4'd3, 4'd0, 4'hB, 1'b1);
        // -8 + -8 = -8
        run_frame("f_minmin", 4'h8, 4'h8, 4'd0, 4'd0, 4'h8, 1'b1);
        // Order matters: 7, +1 -> 7, -8 -> -1, +0 -> -1 (0 would mean clamping at frame end)
        run_frame("f_order", 4'd7, 4'd1, 4'h8, 4'd0, 4'hF, 1'b1);
        // Mixed signs never clamp: 7-8=-1, -1+7=6, 6-8=-2
        run_frame("f_mixed", 4'd7, 4'h8, 4'd7, 4'h8, 4'hE, 1'b0);

        // Backpressure: 1,2,3 gives 6, then 6+4 overflows and clamps to 7
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            step();
        end
        in_data = 4'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data",  {28'd0, out_data},  32'h7);
            step();
        end
        chk_sat("bp_sat", 1'b1);
        out_ready = 1'b1;
        step();
        chk("bp_release", {31'd0, out_valid}, 32'd0);
        run_frame("f_after_bp", 4'd1, 4'd1, 4'd1, 4'd1, 4'h4, 1'b0);

        // Reset mid-frame: the partial 5+5 (clamped) result is discarded
        in_valid = 1'b1;
        in_data  = 4'd5;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data",  {28'd0, out_data},  32'd0);
        chk("mid_rst_ready2", {31'd0, in_ready}, 32'd0);
        chk_sat("mid_rst_sat", 1'b0);
        rst = 1'b0;
        #1;
        run_frame("f_after_rst", 4'd1, 4'd1, 4'd1, 4'd1, 4'h4, 1'b0);

        // COUNT=1 pass-through: -3 then 6. in_ready sequence is 1,0,1,0.
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        in_data1   = 4'hD;
        chk("c1_ready0", {31'd0, in_ready1}, 32'd1);
        step();
        chk("c1_ready1", {31'd0, in_ready1},  32'd0);
        chk("c1_valid1", {31'd0, out_valid1}, 32'd1);
        chk("c1_data1",  {28'd0, out_data1},  32'hD);
        in_data1 = 4'd6;
        step();
        chk("c1_ready2", {31'd0, in_ready1},  32'd1);
        chk("c1_valid2", {31'd0, out_valid1}, 32'd0);
        step();
        in_valid1 = 1'b0;
        chk("c1_ready3", {31'd0, in_ready1},  32'd0);
        chk("c1_valid3", {31'd0, out_valid1}, 32'd1);
        chk("c1_data3",  {28'd0, out_data1},  32'h6);
        step();
        chk("c1_idle", {31'd0, out_valid1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
